// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, divider state encoding, signed minimum.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package alu_pkg;

  localparam int XLEN  = 64;
  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_FIX    = 2'd2
  } div_state_t;

  localparam logic [XLEN-1:0] SIGNED_MIN = 64'h8000_0000_0000_0000;

endpackage

// File: rtl/add_sub_64bit.sv
// 64-bit adder/subtractor: mode=0 computes a+b, mode=1 computes a-b.
// Latency: combinational.
// Backpressure: none; carry_flag=1 on subtract means no borrow occurred.
module add_sub_64bit
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            mode,
  output logic [XLEN-1:0] result,
  output logic            carry_flag
);

  logic [XLEN-1:0] b_eff;

  // Subtract is a + ~b + 1, so the carry out reads as "no borrow"
  assign b_eff = mode ? ~b : b;
  assign {carry_flag, result} = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, mode};

endmodule

// File: rtl/div_64bit_iterative.sv
// Restoring shift-subtract divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Latency: fixed, done pulses in the cycle after the 65th edge following acceptance.
// Backpressure: start is ignored while busy; results hold until the next done.
module div_64bit_iterative
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            div_by_zero,
  output logic            overflow_flag
);

  div_state_t       state_q;
  logic [XLEN-1:0]  dvd_q;       // dividend, shifts left; quotient bits enter at [0]
  logic [XLEN-1:0]  dvs_q;       // |divisor|
  logic [XLEN-1:0]  rem_q;       // partial remainder
  logic [CNT_W-1:0] cnt_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic             dbz_pend_q;  // flags computed at capture, published at FIX
  logic             ovf_pend_q;
  logic             busy_q;
  logic             done_q;
  logic [XLEN-1:0]  quotient_q;
  logic [XLEN-1:0]  remainder_q;
  logic             dbz_q;
  logic             ovf_q;

  logic [XLEN-1:0]  sh;
  logic [XLEN-1:0]  diff;
  logic             no_borrow;
  logic             take;
  logic [XLEN-1:0]  rem_d;
  logic             sd;
  logic             sv;

  function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] x);
    return ~x + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  // Trial subtract on the shifted remainder; rem_q[63] is the implicit 65th bit of sh
  assign sh = {rem_q[XLEN-2:0], dvd_q[XLEN-1]};

  add_sub_64bit u_sub (
    .a          (sh),
    .b          (dvs_q),
    .mode       (1'b1),
    .result     (diff),
    .carry_flag (no_borrow)
  );

  assign take  = rem_q[XLEN-1] | no_borrow;
  assign rem_d = take ? diff : sh;
  assign sd    = is_signed & dividend[XLEN-1];
  assign sv    = is_signed & divisor[XLEN-1];

  // Control FSM, iteration datapath and registered results
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dbz_pend_q  <= 1'b0;
      ovf_pend_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && !busy_q) begin
            dvd_q      <= sd ? neg(dividend) : dividend;
            dvs_q      <= sv ? neg(divisor) : divisor;
            rem_q      <= '0;
            cnt_q      <= '0;
            q_neg_q    <= sd ^ sv;
            r_neg_q    <= sd;
            dbz_pend_q <= (divisor == '0);
            ovf_pend_q <= is_signed && (dividend == SIGNED_MIN) && (divisor == '1);
            busy_q     <= 1'b1;
            state_q    <= ST_DIVIDE;
          end
        end
        ST_DIVIDE: begin
          dvd_q <= {dvd_q[XLEN-2:0], take};
          rem_q <= rem_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          quotient_q  <= q_neg_q ? neg(dvd_q) : dvd_q;
          remainder_q <= r_neg_q ? neg(rem_q) : rem_q;
          dbz_q       <= dbz_pend_q;
          ovf_q       <= ovf_pend_q;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign quotient      = quotient_q;
  assign remainder     = remainder_q;
  assign div_by_zero   = dbz_q;
  assign overflow_flag = ovf_q;

endmodule

// File: tb/tb_div_64bit_iterative.sv
// Directed-vector bench for the iterative divider.
// Latency: checks fixed 65-edge turnaround after acceptance.
// Backpressure: exercises start-while-busy and start-in-done-cycle.
module tb_div_64bit_iterative;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        busy;
  logic        done;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic        div_by_zero;
  logic        overflow_flag;

  int checks = 0;
  int errors = 0;

  div_64bit_iterative dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .is_signed     (is_signed),
    .dividend      (dividend),
    .divisor       (divisor),
    .busy          (busy),
    .done          (done),
    .quotient      (quotient),
    .remainder     (remainder),
    .div_by_zero   (div_by_zero),
    .overflow_flag (overflow_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request for a single edge; returns 1 ns after the accepting edge
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic s);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges after acceptance until done, plus cycles busy was seen high
  task automatic wait_done(output int lat, output int bcnt, output bit timeout);
    lat     = 0;
    bcnt    = busy ? 1 : 0;
    timeout = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) begin
        timeout = 1'b0;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (quotient !== 64'd0) begin errors++; $display("FAIL reset_q got %h want 0", quotient); end
    checks++; if (remainder !== 64'd0) begin errors++; $display("FAIL reset_r got %h want 0", remainder); end
    checks++; if ({div_by_zero, overflow_flag} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {div_by_zero, overflow_flag}); end
  endtask

  task automatic test_divu();
    int lat, bcnt; bit to;
    issue(64'd100, 64'd7, 1'b0);
    wait_done(lat, bcnt, to);
    checks++; if (to) begin errors++; $display("FAIL divu_timeout no done within 200 cycles"); end
    checks++; if (lat != 65) begin errors++; $display("FAIL divu_latency got %0d want 65 edges after accept", lat); end
    checks++; if (bcnt != 65) begin errors++; $display("FAIL divu_busy_cycles got %0d want 65", bcnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL divu_busy_at_done got %b want 0", busy); end
    checks++; if (quotient !== 64'd14) begin errors++; $display("FAIL divu_q got %h want %h", quotient, 64'd14); end
    checks++; if (remainder !== 64'd2) begin errors++; $display("FAIL divu_r got %h want %h", remainder, 64'd2); end
    checks++; if ({div_by_zero, overflow_flag} !== 2'b00) begin errors++; $display("FAIL divu_flags got %b want 00", {div_by_zero, overflow_flag}); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL divu_done_pulse got %b want 0", done); end
    checks++; if (quotient !== 64'd14) begin errors++; $display("FAIL divu_q_hold got %h want %h", quotient, 64'd14); end
  endtask

  task automatic test_signed();
    int lat, bcnt; bit to;
    // -7 / 2 -> -3 rem -1
    issue(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1);
    wait_done(lat, bcnt, to);
    checks++; if (to || quotient !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL sdiv_m7_2_q got %h want %h", quotient, 64'hFFFF_FFFF_FFFF_FFFD); end
    checks++; if (remainder !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL sdiv_m7_2_r got %h want %h", remainder, 64'hFFFF_FFFF_FFFF_FFFF); end
    // 7 / -2 -> -3 rem 1
    issue(64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    wait_done(lat, bcnt, to);
    checks++; if (to || quotient !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL sdiv_7_m2_q got %h want %h", quotient, 64'hFFFF_FFFF_FFFF_FFFD); end
    checks++; if (remainder !== 64'd1) begin errors++; $display("FAIL sdiv_7_m2_r got %h want %h", remainder, 64'd1); end
    // -7 / -2 -> 3 rem -1
    issue(64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    wait_done(lat, bcnt, to);
    checks++; if (to || quotient !== 64'd3) begin errors++; $display("FAIL sdiv_m7_m2_q got %h want %h", quotient, 64'd3); end
    checks++; if (remainder !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL sdiv_m7_m2_r got %h want %h", remainder, 64'hFFFF_FFFF_FFFF_FFFF); end
    // same bit pattern unsigned: (2^64-7) / 2 -> 0x7FFF...FFFC rem 1
    issue(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0);
    wait_done(lat, bcnt, to);
    checks++; if (to || quotient !== 64'h7FFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL udiv_big_q got %h want %h", quotient, 64'h7FFF_FFFF_FFFF_FFFC); end
    checks++; if (remainder !== 64'd1) begin errors++; $display("FAIL udiv_big_r got %h want %h", remainder, 64'd1); end
  endtask

  task automatic test_div_zero();
    int lat, bcnt; bit to;
    issue(64'd5, 64'd0, 1'b0);
    wait_done(lat, bcnt, to);
    checks++; if (to || lat != 65) begin errors++; $display("FAIL dbz_u_latency got %0d want 65", lat); end
    checks++; if (quotient !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL dbz_u_q got %h want all ones", quotient); end
    checks++; if (remainder !== 64'd5) begin errors++; $display("FAIL dbz_u_r got %h want %h", remainder, 64'd5); end
    checks++; if ({div_by_zero, overflow_flag} !== 2'b10) begin errors++; $display("FAIL dbz_u_flags got %b want 10", {div_by_zero, overflow_flag}); end
    issue(64'd5, 64'd0, 1'b1);
    wait_done(lat, bcnt, to);
    checks++; if (to || quotient !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL dbz_s_q got %h want -1", quotient); end
    checks++; if (remainder !== 64'd5) begin errors++; $display("FAIL dbz_s_r got %h want %h", remainder, 64'd5); end
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_s_flag got %b want 1", div_by_zero); end
  endtask

  task automatic test_overflow();
    int lat, bcnt; bit to;
    issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    wait_done(lat, bcnt, to);
    checks++; if (to || quotient !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL ovf_q got %h want %h", quotient, 64'h8000_0000_0000_0000); end
    checks++; if (remainder !== 64'd0) begin errors++; $display("FAIL ovf_r got %h want 0", remainder); end
    checks++; if ({div_by_zero, overflow_flag} !== 2'b01) begin errors++; $display("FAIL ovf_flags got %b want 01", {div_by_zero, overflow_flag}); end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt; bit to;
    issue(64'd100, 64'd7, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    // intruding request while busy; must leave the running op untouched
    dividend = 64'd50; divisor = 64'd5; is_signed = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_mid got %b want 1", busy); end
    wait_done(lat, bcnt, to);
    lat = lat + 10;
    checks++; if (to || lat != 65) begin errors++; $display("FAIL b2b_latency got %0d want 65", lat); end
    checks++; if (quotient !== 64'd14) begin errors++; $display("FAIL b2b_q got %h want %h", quotient, 64'd14); end
    checks++; if (remainder !== 64'd2) begin errors++; $display("FAIL b2b_r got %h want %h", remainder, 64'd2); end
    // start presented in the done cycle is accepted
    issue(64'd1000, 64'd10, 1'b0);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_accept_in_done got busy=%b done=%b want busy=1 done=0", busy, done); end
    repeat (20) @(posedge clk);
    #1;
    checks++; if (quotient !== 64'd14) begin errors++; $display("FAIL b2b_hold_mid got %h want %h", quotient, 64'd14); end
    wait_done(lat, bcnt, to);
    lat = lat + 20;
    checks++; if (to || lat != 65) begin errors++; $display("FAIL b2b2_latency got %0d want 65", lat); end
    checks++; if (quotient !== 64'd100 || remainder !== 64'd0) begin errors++; $display("FAIL b2b2_qr got %h/%h want %h/%h", quotient, remainder, 64'd100, 64'd0); end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt; bit to;
    bit seen_done;
    issue(64'd12345, 64'd17, 1'b0);
    repeat (29) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl got busy=%b done=%b want 0 0", busy, done); end
    checks++; if (quotient !== 64'd0 || remainder !== 64'd0) begin errors++; $display("FAIL rstmid_out got %h/%h want 0/0", quotient, remainder); end
    checks++; if ({div_by_zero, overflow_flag} !== 2'b00) begin errors++; $display("FAIL rstmid_flags got %b want 00", {div_by_zero, overflow_flag}); end
    seen_done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen_done = 1'b1;
    end
    checks++; if (seen_done) begin errors++; $display("FAIL rstmid_no_done got activity=1 want 0"); end
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b0);
    wait_done(lat, bcnt, to);
    checks++; if (to || lat != 65) begin errors++; $display("FAIL rstmid_next_latency got %0d want 65", lat); end
    checks++; if (quotient !== 64'h5555_5555_5555_5555) begin errors++; $display("FAIL rstmid_next_q got %h want %h", quotient, 64'h5555_5555_5555_5555); end
    checks++; if (remainder !== 64'd0) begin errors++; $display("FAIL rstmid_next_r got %h want 0", remainder); end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
